// File: rtl/ssp_port_arbiter.sv
// Round-robin arbiter that shares one SSP processor interface among NUM_REQ byte
// requesters. A tag FIFO records which requester issued each TX byte so that the
// matching RX byte can be routed back to the same requester.
module ssp_port_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                 PCLK,
  input  logic                 CLEAR_B,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 PSEL,
  output logic                 PWRITE,
  output logic [7:0]           PWDATA,
  input  logic [7:0]           PRDATA,
  input  logic                 SSPTXINTR,
  input  logic                 SSPRXINTR,
  output logic [3:0]           outstanding,
  output logic                 rx_drop
);

  localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PtrW = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StGap} state_e;

  state_e          state_q;
  logic [IdW-1:0]  rr_q;
  logic [IdW-1:0]  grant_id;
  logic [IdW-1:0]  rr_next;
  logic [IdW:0]    cand;
  logic            grant_found;
  logic            wr_go;
  logic [7:0]      req_bytes [NUM_REQ];
  logic [IdW-1:0]  tag_mem [TAG_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [3:0]      count_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // First valid requester at or after the round-robin pointer, wrapping at NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_q} + (IdW+1)'(k);
      if (cand >= (IdW+1)'(NUM_REQ)) cand = cand - (IdW+1)'(NUM_REQ);
      if (!grant_found && req_valid[cand[IdW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[IdW-1:0];
      end
    end
  end

  // A write may start only from IDLE when no read is pending, the SSP TX FIFO has
  // room and a tag slot is free; the accept pulse is combinational in that cycle.
  always_comb begin
    wr_go     = (state_q == StIdle) && !SSPRXINTR && grant_found && !SSPTXINTR &&
                (count_q < 4'(TAG_DEPTH));
    req_ready = wr_go ? (NUM_REQ'(1) << grant_id) : '0;
    rr_next   = (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  assign outstanding = count_q;

  // Access sequencer: one registered PSEL cycle per access, then a GAP cycle.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state_q   <= StIdle;
      PSEL      <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rx_drop   <= 1'b0;
      rr_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int unsigned i = 0; i < TAG_DEPTH; i++) tag_mem[i] <= '0;
    end else begin
      rsp_valid <= '0;
      rx_drop   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (SSPRXINTR) begin
            state_q <= StRd;
            PSEL    <= 1'b1;
            PWRITE  <= 1'b0;
          end else if (wr_go) begin
            state_q           <= StWr;
            PSEL              <= 1'b1;
            PWRITE            <= 1'b1;
            PWDATA            <= req_bytes[grant_id];
            tag_mem[wr_ptr_q] <= grant_id;
            wr_ptr_q          <= wr_ptr_q + 1'b1;
            count_q           <= count_q + 1'b1;
            rr_q              <= rr_next;
          end
        end
        StWr: begin
          state_q <= StGap;
          PSEL    <= 1'b0;
          PWRITE  <= 1'b0;
        end
        StRd: begin
          state_q <= StGap;
          PSEL    <= 1'b0;
          // An RX byte with no outstanding tag has no owner and is discarded.
          if (count_q != '0) begin
            rsp_valid <= NUM_REQ'(1) << tag_mem[rd_ptr_q];
            rsp_data  <= PRDATA;
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            count_q   <= count_q - 1'b1;
          end else begin
            rx_drop <= 1'b1;
          end
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssp_port_arbiter.sv
// Self-checking bench for ssp_port_arbiter: expected writes and responses are
// queued as stimulus is set up and compared when the DUT produces them.
module tb_ssp_port_arbiter;

  logic        PCLK = 1'b0;
  logic        CLEAR_B;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        PSEL;
  logic        PWRITE;
  logic [7:0]  PWDATA;
  logic [7:0]  PRDATA;
  logic        SSPTXINTR;
  logic        SSPRXINTR;
  logic [3:0]  outstanding;
  logic        rx_drop;

  ssp_port_arbiter #(.NUM_REQ(4), .TAG_DEPTH(8)) dut (
    .PCLK        (PCLK),
    .CLEAR_B     (CLEAR_B),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .PSEL        (PSEL),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .SSPTXINTR   (SSPTXINTR),
    .SSPRXINTR   (SSPRXINTR),
    .outstanding (outstanding),
    .rx_drop     (rx_drop)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: expected write bytes, expected {rsp_valid, rsp_data}.
  logic [7:0]  exp_wr[$];
  logic [11:0] exp_rsp[$];
  int          wr_cyc_q[$];
  int          wr_count = 0;
  int          rd_count = 0;
  int          drop_count = 0;
  int          last_rd_cyc = 0;

  // Values sampled at the most recent falling edge.
  logic       s_psel;
  logic [3:0] s_ready;
  logic [3:0] s_outst;

  // Per-requester byte sources.
  logic [7:0] src_mem [4][16];
  int         src_wr [4];
  int         src_rd [4];

  task automatic queue_byte(input int id, input logic [7:0] b);
    src_mem[id][src_wr[id]] = b;
    src_wr[id]++;
  endtask

  task automatic load(input int id);
    if (src_rd[id] < src_wr[id]) begin
      req_data[8*id +: 8] = src_mem[id][src_rd[id]];
      src_rd[id]++;
      req_valid[id] = 1'b1;
    end else begin
      req_valid[id] = 1'b0;
    end
  endtask

  // One clock: sample and score outputs on the falling edge, then let accepted
  // requesters present their next byte just after the rising edge.
  task automatic step();
    logic [3:0]  acc;
    logic [7:0]  e;
    logic [11:0] r;
    @(negedge PCLK);
    s_psel  = PSEL;
    s_ready = req_ready;
    s_outst = outstanding;
    acc     = req_valid & req_ready;
    if (PSEL && PWRITE) begin
      wr_count++;
      wr_cyc_q.push_back(cyc);
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: PWDATA=%h, required no write", PWDATA);
      end else begin
        e = exp_wr.pop_front();
        if (PWDATA !== e) begin
          errors++;
          $display("FAIL write_data: PWDATA=%h, required %h", PWDATA, e);
        end
      end
    end
    if (PSEL && !PWRITE) begin
      rd_count++;
      last_rd_cyc = cyc;
    end
    if (rsp_valid !== 4'b0) begin
      checks++;
      if (exp_rsp.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: rsp_valid=%b rsp_data=%h, required none",
                 rsp_valid, rsp_data);
      end else begin
        r = exp_rsp.pop_front();
        if ({rsp_valid, rsp_data} !== r) begin
          errors++;
          $display("FAIL rsp: rsp_valid=%b rsp_data=%h, required %b %h",
                   rsp_valid, rsp_data, r[11:8], r[7:0]);
        end
      end
    end
    if (rx_drop === 1'b1) begin
      drop_count++;
      checks++;
      if (rsp_valid !== 4'b0) begin
        errors++;
        $display("FAIL drop_rsp: rsp_valid=%b, required 0000", rsp_valid);
      end
    end
    @(posedge PCLK);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) load(i);
  endtask

  task automatic wait_writes(input int target, input int bound, input string name);
    int n = 0;
    while (wr_count < target && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (wr_count != target) begin
      errors++;
      $display("FAIL %s: writes=%0d, required %0d", name, wr_count, target);
    end
  endtask

  task automatic do_read(input logic [7:0] data, input string name);
    int r0 = rd_count;
    int n  = 0;
    PRDATA    = data;
    SSPRXINTR = 1'b1;
    while (rd_count == r0 && n < 10) begin
      step();
      n++;
    end
    SSPRXINTR = 1'b0;
    checks++;
    if (rd_count != r0 + 1) begin
      errors++;
      $display("FAIL %s: reads=%0d, required %0d", name, rd_count, r0 + 1);
    end
    step();
    step();
  endtask

  task automatic test_reset();
    CLEAR_B   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    PRDATA    = '0;
    SSPTXINTR = 1'b0;
    SSPRXINTR = 1'b0;
    #12;
    checks++;
    if ({PSEL, PWRITE, PWDATA, rsp_valid, rsp_data, outstanding, rx_drop} !== 27'b0) begin
      errors++;
      $display("FAIL reset_state: psel=%b pwrite=%b pwdata=%h rsp_valid=%b rsp_data=%h out=%0d drop=%b, required all 0",
               PSEL, PWRITE, PWDATA, rsp_valid, rsp_data, outstanding, rx_drop);
    end
    checks++;
    if (req_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b, required 0000", req_ready);
    end
    @(posedge PCLK);
    #1;
    CLEAR_B = 1'b1;
    step();
    step();
    // Reset in the middle of a write access.
    queue_byte(0, 8'h11);
    load(0);
    @(negedge PCLK);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_ready: req_ready=%b, required 0001", req_ready);
    end
    @(posedge PCLK);
    #1;
    req_valid[0] = 1'b0;
    checks++;
    if (PSEL !== 1'b1 || PWRITE !== 1'b1 || outstanding !== 4'd1) begin
      errors++;
      $display("FAIL mid_wr: psel=%b pwrite=%b out=%0d, required 1 1 1", PSEL, PWRITE,
               outstanding);
    end
    CLEAR_B = 1'b0;
    #1;
    checks++;
    if (PSEL !== 1'b0 || outstanding !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: psel=%b out=%0d, required 0 0", PSEL, outstanding);
    end
    #2;
    CLEAR_B = 1'b1;
    step();
    step();
  endtask

  task automatic test_round_robin();
    int w0 = wr_count;
    for (int i = 0; i < 4; i++) begin
      queue_byte(i, 8'hA0 + 8'(i));
      exp_wr.push_back(8'hA0 + 8'(i));
    end
    queue_byte(0, 8'hA4);
    exp_wr.push_back(8'hA4);
    wr_cyc_q.delete();
    for (int i = 0; i < 4; i++) load(i);
    wait_writes(w0 + 5, 30, "rr_writes");
    for (int i = 1; i < wr_cyc_q.size(); i++) begin
      checks++;
      if (wr_cyc_q[i] - wr_cyc_q[i-1] != 3) begin
        errors++;
        $display("FAIL rr_spacing: gap=%0d, required 3", wr_cyc_q[i] - wr_cyc_q[i-1]);
      end
    end
    step();
    checks++;
    if (s_outst !== 4'd5) begin
      errors++;
      $display("FAIL rr_outstanding: out=%0d, required 5", s_outst);
    end
    exp_rsp.push_back({4'b0001, 8'hB0});
    exp_rsp.push_back({4'b0010, 8'hB1});
    exp_rsp.push_back({4'b0100, 8'hB2});
    exp_rsp.push_back({4'b1000, 8'hB3});
    exp_rsp.push_back({4'b0001, 8'hB4});
    for (int i = 0; i < 5; i++) do_read(8'hB0 + 8'(i), "rr_drain");
  endtask

  task automatic test_routing();
    int w0 = wr_count;
    queue_byte(2, 8'h5A);
    exp_wr.push_back(8'h5A);
    load(2);
    wait_writes(w0 + 1, 10, "route_write");
    step();
    checks++;
    if (s_outst !== 4'd1) begin
      errors++;
      $display("FAIL route_out_before: out=%0d, required 1", s_outst);
    end
    exp_rsp.push_back({4'b0100, 8'hC3});
    do_read(8'hC3, "route_read");
    checks++;
    if (s_outst !== 4'd0) begin
      errors++;
      $display("FAIL route_out_after: out=%0d, required 0", s_outst);
    end
  endtask

  task automatic test_back_pressure();
    int w0 = wr_count;
    int n  = 0;
    SSPTXINTR = 1'b1;
    queue_byte(0, 8'h77);
    load(0);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (s_psel !== 1'b0 || s_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold: psel=%b req_ready=%b, required 0 0000", s_psel, s_ready);
      end
    end
    exp_wr.push_back(8'h77);
    SSPTXINTR = 1'b0;
    while (wr_count == w0 && n < 2) begin
      step();
      n++;
    end
    checks++;
    if (wr_count != w0 + 1) begin
      errors++;
      $display("FAIL bp_release: writes=%0d, required %0d within 2 cycles", wr_count, w0 + 1);
    end
    exp_rsp.push_back({4'b0001, 8'h5C});
    do_read(8'h5C, "bp_drain");
  endtask

  task automatic test_tag_full();
    int w0 = wr_count;
    for (int i = 0; i < 9; i++) begin
      queue_byte(3, 8'hC0 + 8'(i));
      exp_wr.push_back(8'hC0 + 8'(i));
    end
    load(3);
    wait_writes(w0 + 8, 40, "full_fill");
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (s_psel !== 1'b0 || s_ready !== 4'b0 || s_outst !== 4'd8) begin
        errors++;
        $display("FAIL full_stall: psel=%b req_ready=%b out=%0d, required 0 0000 8",
                 s_psel, s_ready, s_outst);
      end
    end
    exp_rsp.push_back({4'b1000, 8'hD0});
    do_read(8'hD0, "full_read");
    wait_writes(w0 + 9, 10, "full_ninth");
    for (int i = 0; i < 8; i++) begin
      exp_rsp.push_back({4'b1000, 8'hE0 + 8'(i)});
      do_read(8'hE0 + 8'(i), "full_drain");
    end
    checks++;
    if (s_outst !== 4'd0) begin
      errors++;
      $display("FAIL full_empty: out=%0d, required 0", s_outst);
    end
  endtask

  task automatic test_unsolicited();
    int d0 = drop_count;
    do_read(8'hEE, "unsol_read");
    checks++;
    if (drop_count != d0 + 1) begin
      errors++;
      $display("FAIL unsol_drop: drops=%0d, required %0d", drop_count, d0 + 1);
    end
  endtask

  task automatic test_simultaneous();
    int w0 = wr_count;
    int r0 = rd_count;
    int n  = 0;
    queue_byte(1, 8'h42);
    exp_wr.push_back(8'h42);
    PRDATA    = 8'h24;
    SSPRXINTR = 1'b1;
    load(1);
    while (rd_count == r0 && n < 10) begin
      step();
      n++;
    end
    SSPRXINTR = 1'b0;
    checks++;
    if (rd_count != r0 + 1 || wr_count != w0) begin
      errors++;
      $display("FAIL sim_order: reads=%0d writes=%0d, required %0d %0d", rd_count, wr_count,
               r0 + 1, w0);
    end
    wait_writes(w0 + 1, 10, "sim_write");
    checks++;
    if (wr_cyc_q[$] - last_rd_cyc != 3) begin
      errors++;
      $display("FAIL sim_gap: write-read=%0d, required 3", wr_cyc_q[$] - last_rd_cyc);
    end
    exp_rsp.push_back({4'b0010, 8'h31});
    do_read(8'h31, "sim_drain");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    test_reset();
    test_round_robin();
    test_routing();
    test_back_pressure();
    test_tag_full();
    test_unsolicited();
    test_simultaneous();
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (exp_wr.size() != 0 || exp_rsp.size() != 0) begin
      errors++;
      $display("FAIL leftover: writes=%0d rsps=%0d, required 0 0", exp_wr.size(),
               exp_rsp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
